fetch_prefetch_unit: RTL and testbench

// - Instruction-fetch front end. Owns the PC and issues word fetches to instruction memory over a valid/ready request bus.
// - Buffers {pc, instr} pairs in a small prefetch queue and hands them to the IF/ID register through a valid/ready output.
// - Branch redirects from ID flush the queue and discard stale in-flight responses, so IF/ID only ever sees correct-path instructions.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/fetch_prefetch_unit.sv | 92 +++++++++
 tb/tb_fetch_prefetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: prefetch queue entry, in-flight fetch tag and fetch FSM states.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        epoch;
    } fetch_tag_t;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and a flush that drops all contents in one cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] popData,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr, wrPtr;
    logic             doPush, doPop;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC, credit-limited fetch requests, epoch-tagged responses, prefetch queue to IF/ID.
module fetch_prefetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    fetch_state_e  state, stateNext;
    logic [31:0]   fetchPc;
    logic          epoch;
    logic [OW-1:0] outstanding, staleCnt;
    fetch_entry_t  qIn, qOut;
    fetch_tag_t    tagIn, tagOut;
    logic [CW-1:0] qCount;
    logic          qFull, qEmpty, tagFull, tagEmpty;
    logic          credit, reqFire, rspFire, qPush, qPop;

    // Outstanding requests are exactly the tags awaiting a response; tagFull means outstanding == MAX_OUT.
    assign credit         = (32'(qCount) + 32'(outstanding)) < 32'(DEPTH);
    assign imem_req_valid = !rst && (state == RUN) && !redirect && !tagFull && credit;
    assign imem_req_addr  = fetchPc;
    assign reqFire        = imem_req_valid && imem_req_ready;
    assign rspFire        = imem_rsp_valid && !tagEmpty;

    // Everything still in flight during DRAIN predates the latest redirect, whatever its epoch bit says.
    assign qPush    = rspFire && (state == RUN) && (tagOut.epoch == epoch) && !redirect && (!qFull || qPop);
    assign qPop     = id_valid && id_ready;
    assign qIn      = '{pc: tagOut.addr, instr: imem_rsp_data};
    assign tagIn    = '{addr: fetchPc, epoch: epoch};
    assign id_valid = !qEmpty;
    assign id_instr = qEmpty ? NOP_INSTR : qOut.instr;
    assign id_pc    = qEmpty ? 32'h0 : qOut.pc;

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) prefetchQ (
        .clk(clk), .rst(rst), .push(qPush), .pop(qPop), .flush(redirect),
        .pushData(qIn), .popData(qOut), .count(qCount), .full(qFull), .empty(qEmpty)
    );

    sync_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(MAX_OUT)) tagQ (
        .clk(clk), .rst(rst), .push(reqFire), .pop(rspFire), .flush(1'b0),
        .pushData(tagIn), .popData(tagOut), .count(outstanding), .full(tagFull), .empty(tagEmpty)
    );

    // A second redirect while older-epoch fetches are still in flight would make the 1-bit epoch alias,
    // so that case drains as well as the outstanding==MAX_OUT case.
    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (redirect && (tagFull || staleCnt != '0)) stateNext = DRAIN;
            DRAIN:   if (outstanding == '0) stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fetchPc  <= RESET_PC;
            epoch    <= 1'b0;
            staleCnt <= '0;
        end else begin
            state <= stateNext;
            if (redirect) begin
                fetchPc  <= redirect_pc;
                epoch    <= ~epoch;
                staleCnt <= outstanding - OW'(rspFire);
            end else begin
                if (reqFire) fetchPc <= fetchPc + 32'd4;
                if (rspFire && staleCnt != '0) staleCnt <= staleCnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench: random memory/IF-ID timing and redirects against a correct-path PC stream model.
module tb_fetch_prefetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;

    int checks, failures, cyc, lat, reqCount, popCount;
    logic [31:0] pendAddr[$];
    int          pendDue[$];
    logic [31:0] expQ[$];
    logic [31:0] lastExp, expReqAddr, holdAddr;
    logic        holdPending;

    fetch_prefetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void refill();
        while (expQ.size() < 16) begin
            lastExp += 32'd4;
            expQ.push_back(lastExp);
        end
    endfunction

    // One cycle: memory model answers in order after `lat` cycles; inputs applied at negedge, sampled #1 later.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit reqRdy, input bit idRdy);
        int outBefore;
        @(negedge clk);
        cyc++;
        outBefore = pendAddr.size();
        if (pendAddr.size() > 0 && pendDue[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~pendAddr[0];
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect       = redir;
        redirect_pc    = rpc;
        imem_req_ready = reqRdy;
        id_ready       = idRdy;
        if (redir) begin
            expQ.delete();
            lastExp = rpc - 32'd4;
        end
        refill();
        #1;
        if (redir) chk("redirect_blocks_req", 32'(imem_req_valid), 32'd0);
        if (holdPending && imem_req_valid) chk("req_addr_stable", imem_req_addr, holdAddr);
        holdPending = imem_req_valid && !imem_req_ready;
        holdAddr    = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr_seq", imem_req_addr, expReqAddr);
            chk("credit_max_out", 32'(outBefore < MAX_OUT), 32'd1);
            expReqAddr += 32'd4;
            pendAddr.push_back(imem_req_addr);
            pendDue.push_back(cyc + lat);
            reqCount++;
        end
        if (redir) expReqAddr = rpc;
    endtask

    task automatic doReset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, NOP);
        chk("rst_id_pc", id_pc, 32'd0);
        pendAddr.delete();
        pendDue.delete();
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        holdPending    = 1'b0;
        repeat (2) @(negedge clk);
        expQ.delete();
        lastExp    = RESET_PC - 32'd4;
        refill();
        expReqAddr = RESET_PC;
        reqCount   = 0;
        popCount   = 0;
        rst        = 1'b0;
    endtask

    // Monitor: every accepted IF/ID transfer must be the next correct-path pc with its memory word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (id_valid && id_ready && !redirect) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_underflow actual_pc=%h expected=none", id_pc);
                    end else begin
                        e = expQ.pop_front();
                        chk("id_pc", id_pc, e);
                        chk("id_instr", id_instr, ~e);
                        popCount++;
                    end
                end else if (!id_valid) begin
                    chk("idle_instr", id_instr, NOP);
                    chk("idle_pc", id_pc, 32'd0);
                end
            end
        end
    end

    initial begin
        int firstValid, validCnt, popsBefore;
        logic [31:0] rpc;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;
        checks = 0; failures = 0; cyc = 0; lat = 1; reqCount = 0; popCount = 0;
        holdPending = 1'b0; lastExp = '0; expReqAddr = RESET_PC; holdAddr = '0;
        doReset();

        // Startup: first id_valid two cycles after the first request, then one per cycle.
        firstValid = -1;
        validCnt   = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (id_valid && firstValid < 0) firstValid = i;
            if (i >= 2 && id_valid) validCnt++;
        end
        chk("startup_latency", 32'(firstValid), 32'd2);
        chk("stream_rate", 32'(validCnt), 32'd4);

        // Memory not ready for 3 cycles: address must hold, no pc skipped.
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);

        // IF/ID stalled: queue fills to DEPTH and requests stop.
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("fill_occupancy", 32'(reqCount - popCount - pendAddr.size()), 32'(DEPTH));
        chk("fill_req_stopped", 32'(imem_req_valid), 32'd0);
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with MAX_OUT responses outstanding on a 3-cycle memory.
        lat = 3;
        for (int k = 0; k < 10 && pendAddr.size() != MAX_OUT; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("outstanding_reached", 32'(pendAddr.size()), 32'(MAX_OUT));
        step(1'b1, 32'h100, 1'b1, 1'b1);
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Back-to-back redirects while draining.
        for (int k = 0; k < 10 && pendAddr.size() != MAX_OUT; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b1, 32'h300, 1'b1, 1'b1);
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Address wrap past 0xFFFF_FFFC.
        lat = 1;
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Random timing and redirects.
        for (int seg = 0; seg < 12; seg++) begin
            lat = $urandom_range(1, 4);
            for (int i = 0; i < 200; i++) begin
                rpc = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFF0))
                      + 32'(4 * $urandom_range(0, 3));
                step($urandom_range(0, 99) < 4, rpc, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
            end
        end

        popsBefore = popCount;
        repeat (40) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("liveness", 32'(popCount > popsBefore), 32'd1);

        // Reset mid-stream, then fetch restarts from RESET_PC.
        doReset();
        lat = 2;
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("restart_progress", 32'(popCount > 0), 32'd1);

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
